// File: rtl/float_copro_ctrl.sv
// Float coprocessor controller: registers the LM32 copro request and drives an external datapath.
// It times each opcode with a latency counter and returns the result through the complete/accept handshake.
`timescale 1ns/1ps
module float_copro_ctrl #(
   parameter int DATA_W  = 32,
   parameter int OPC_W   = 11,
   parameter int LAT_ADD = 3,
   parameter int LAT_SUB = 3,
   parameter int LAT_MUL = 1,
   parameter int LAT_DIV = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              copro_valid,
   input  logic              copro_accept,
   input  logic [OPC_W-1:0]  copro_opcode,
   input  logic [DATA_W-1:0] copro_op0,
   input  logic [DATA_W-1:0] copro_op1,
   output logic              copro_complete,
   output logic [DATA_W-1:0] copro_result,
   output logic              copro_error,
   output logic              copro_busy,
   output logic [OPC_W-1:0]  dp_opcode,
   output logic [DATA_W-1:0] dp_op0,
   output logic [DATA_W-1:0] dp_op1,
   input  logic [DATA_W-1:0] dp_result
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int LAT_MAX = max2(max2(LAT_ADD, LAT_SUB), max2(LAT_MUL, LAT_DIV));
   localparam int CNT_W   = (LAT_MAX > 0) ? $clog2(LAT_MAX + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] sel);
      logic [CNT_W-1:0] lat;
      case (sel)
         2'd0:    lat = CNT_W'(LAT_ADD);
         2'd1:    lat = CNT_W'(LAT_SUB);
         2'd2:    lat = CNT_W'(LAT_MUL);
         2'd3:    lat = CNT_W'(LAT_DIV);
         default: lat = CNT_W'(0);
      endcase
      return lat;
   endfunction

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              complete_q;
   logic              error_q;
   logic [DATA_W-1:0] result_q;
   logic [OPC_W-1:0]  dp_opcode_q;
   logic [DATA_W-1:0] dp_op0_q;
   logic [DATA_W-1:0] dp_op1_q;
   logic              opc_legal_s;

   assign opc_legal_s = (copro_opcode < OPC_W'(4));

   // Handshake FSM: capture in IDLE, count down in BUSY, hold the result in DONE until accept or abort
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         complete_q  <= 1'b0;
         error_q     <= 1'b0;
         result_q    <= '0;
         dp_opcode_q <= '0;
         dp_op0_q    <= '0;
         dp_op1_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (copro_valid) begin
                  dp_opcode_q <= copro_opcode;
                  dp_op0_q    <= copro_op0;
                  dp_op1_q    <= copro_op1;
                  if (opc_legal_s) begin
                     cnt_q   <= lat_of(copro_opcode[1:0]);
                     state_q <= ST_BUSY;
                  end else begin
                     // Illegal opcodes bypass the datapath and complete with an error immediately
                     result_q   <= '0;
                     error_q    <= 1'b1;
                     complete_q <= 1'b1;
                     state_q    <= ST_DONE;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (!copro_valid) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else if (cnt_q != CNT_W'(0)) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  result_q   <= dp_result;
                  error_q    <= 1'b0;
                  complete_q <= 1'b1;
                  state_q    <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Accept and abort both release the result; accept simply wins when both apply
               if (copro_accept || !copro_valid) begin
                  complete_q <= 1'b0;
                  error_q    <= 1'b0;
                  state_q    <= ST_IDLE;
               end else begin
                  state_q <= ST_DONE;
               end
            end
            default: begin
               cnt_q      <= '0;
               complete_q <= 1'b0;
               error_q    <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign copro_complete = complete_q;
   assign copro_error    = error_q;
   assign copro_result   = result_q;
   assign copro_busy     = (state_q != ST_IDLE);
   assign dp_opcode      = dp_opcode_q;
   assign dp_op0         = dp_op0_q;
   assign dp_op1         = dp_op1_q;

endmodule

// File: tb/tb_float_copro_ctrl.sv
// Randomized self-checking bench for float_copro_ctrl against a transaction-level model
// of latency, result and handshake behaviour.
`timescale 1ns/1ps
module tb_float_copro_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        copro_valid;
   logic        copro_accept;
   logic [10:0] copro_opcode;
   logic [31:0] copro_op0;
   logic [31:0] copro_op1;
   logic        copro_complete;
   logic [31:0] copro_result;
   logic        copro_error;
   logic        copro_busy;
   logic [10:0] dp_opcode;
   logic [31:0] dp_op0;
   logic [31:0] dp_op1;
   logic [31:0] dp_result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   float_copro_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .copro_valid    (copro_valid),
      .copro_accept   (copro_accept),
      .copro_opcode   (copro_opcode),
      .copro_op0      (copro_op0),
      .copro_op1      (copro_op1),
      .copro_complete (copro_complete),
      .copro_result   (copro_result),
      .copro_error    (copro_error),
      .copro_busy     (copro_busy),
      .dp_opcode      (dp_opcode),
      .dp_op0         (dp_op0),
      .dp_op1         (dp_op1),
      .dp_result      (dp_result)
   );

   // Stand-in combinational datapath: any operand-dependent function will do
   function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [10:0] opc);
      return (a ^ {b[15:0], b[31:16]}) + {21'd0, opc};
   endfunction

   assign dp_result = dp_model(dp_op0, dp_op1, dp_opcode);

   function automatic int lat_ref(input int opc);
      case (opc)
         0:       return 3;
         1:       return 3;
         2:       return 1;
         3:       return 4;
         default: return -1;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_complete"}, {31'd0, copro_complete}, 32'd0);
      check_eq({tag, "_error"},    {31'd0, copro_error},    32'd0);
      check_eq({tag, "_busy"},     {31'd0, copro_busy},     32'd0);
      check_eq({tag, "_result"},   copro_result,            32'd0);
      check_eq({tag, "_dp_opc"},   {21'd0, dp_opcode},      32'd0);
      check_eq({tag, "_dp_op0"},   dp_op0,                  32'd0);
      check_eq({tag, "_dp_op1"},   dp_op1,                  32'd0);
   endtask

   // One transaction; abort_at>=0 drops valid that many cycles after capture
   task automatic run_op(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input int abort_at, input int wait_acc, input bit keep_valid,
                         input bit done_abort);
      bit          legal;
      int          exp_edges;
      int          k;
      logic [31:0] exp_res;
      legal     = (opc < 11'd4);
      exp_edges = legal ? lat_ref(int'(opc)) + 1 : 0;
      exp_res   = legal ? dp_model(a, b, opc) : 32'd0;
      copro_valid  = 1'b1;
      copro_accept = 1'b0;
      copro_opcode = opc;
      copro_op0    = a;
      copro_op1    = b;
      tick();
      check_eq("busy_start", {31'd0, copro_busy}, 32'd1);
      check_eq("dp_opcode",  {21'd0, dp_opcode},  {21'd0, opc});
      check_eq("dp_op0",     dp_op0, a);
      check_eq("dp_op1",     dp_op1, b);
      if (abort_at >= 0 && legal) begin
         for (int i = 0; i < abort_at; i++) tick();
         copro_valid = 1'b0;
         tick();
         check_eq("abort_busy",     {31'd0, copro_busy},     32'd0);
         check_eq("abort_complete", {31'd0, copro_complete}, 32'd0);
         tick();
         tick();
         check_eq("abort_quiet", {31'd0, copro_complete}, 32'd0);
      end else begin
         k = 0;
         while (!copro_complete && k < 20) begin
            copro_op0    = $urandom;
            copro_op1    = $urandom;
            copro_opcode = 11'($urandom_range(0, 3));
            copro_accept = 1'($urandom_range(0, 1));
            tick();
            k++;
         end
         copro_accept = 1'b0;
         check_eq("latency",  32'(k), 32'(exp_edges));
         check_eq("op0_held", dp_op0, a);
         check_eq("op1_held", dp_op1, b);
         check_eq("complete", {31'd0, copro_complete}, 32'd1);
         check_eq("error",    {31'd0, copro_error},    {31'd0, !legal});
         check_eq("result",   copro_result, exp_res);
         for (int i = 0; i < wait_acc; i++) begin
            tick();
            check_eq("hold_complete", {31'd0, copro_complete}, 32'd1);
            check_eq("hold_result",   copro_result, exp_res);
         end
         if (done_abort) begin
            copro_valid = 1'b0;
            tick();
            check_eq("dabort_complete", {31'd0, copro_complete}, 32'd0);
            check_eq("dabort_error",    {31'd0, copro_error},    32'd0);
            check_eq("dabort_busy",     {31'd0, copro_busy},     32'd0);
         end else begin
            copro_accept = 1'b1;
            copro_valid  = keep_valid;
            tick();
            copro_accept = 1'b0;
            check_eq("acc_complete", {31'd0, copro_complete}, 32'd0);
            check_eq("acc_error",    {31'd0, copro_error},    32'd0);
            check_eq("acc_busy",     {31'd0, copro_busy},     32'd0);
         end
      end
   endtask

   // Async reset while an op is in flight (in_done=0) or holding its result (in_done=1)
   task automatic reset_mid(input bit in_done);
      copro_valid  = 1'b1;
      copro_accept = 1'b0;
      copro_opcode = 11'd3;
      copro_op0    = 32'h1234_5678;
      copro_op1    = 32'h9abc_def0;
      tick();
      if (in_done) begin
         for (int i = 0; i < 5; i++) tick();
         check_eq("pre_reset_complete", {31'd0, copro_complete}, 32'd1);
      end else begin
         tick();
         check_eq("pre_reset_busy", {31'd0, copro_busy}, 32'd1);
      end
      #2 reset_n = 1'b0;
      #1 check_all_zero(in_done ? "rst_done" : "rst_busy");
      copro_valid = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      logic [10:0] opc;
      int          ab;
      bit          keep;
      bit          dab;
      reset_n      = 1'b0;
      copro_valid  = 1'b0;
      copro_accept = 1'b0;
      copro_opcode = 11'd0;
      copro_op0    = 32'd0;
      copro_op1    = 32'd0;
      #3 check_all_zero("reset");
      tick();
      reset_n = 1'b1;
      tick();

      run_op(11'd0, 32'h3F80_0000, 32'h4000_0000, -1, 1, 1'b0, 1'b0);
      run_op(11'd3, 32'h4120_0000, 32'h4040_0000, -1, 0, 1'b0, 1'b0);
      run_op(11'd2, 32'hC000_0000, 32'h3F00_0000, -1, 2, 1'b0, 1'b0);
      run_op(11'd1, 32'h0000_0001, 32'hFFFF_FFFF, -1, 0, 1'b0, 1'b1);
      run_op(11'd7, 32'hDEAD_BEEF, 32'hCAFE_F00D, -1, 1, 1'b0, 1'b0);
      run_op(11'd3, 32'h1111_1111, 32'h2222_2222,  1, 0, 1'b0, 1'b0);
      run_op(11'd3, 32'h3333_3333, 32'h4444_4444,  4, 0, 1'b0, 1'b0);
      run_op(11'd0, 32'h5555_5555, 32'h6666_6666, -1, 0, 1'b1, 1'b0);
      run_op(11'd2, 32'h7777_7777, 32'h8888_8888, -1, 0, 1'b0, 1'b0);
      reset_mid(1'b0);
      run_op(11'd1, 32'h0BAD_CAFE, 32'h0000_00FF, -1, 0, 1'b0, 1'b0);
      reset_mid(1'b1);
      run_op(11'd2, 32'hA5A5_A5A5, 32'h5A5A_5A5A, -1, 1, 1'b0, 1'b0);

      keep = 1'b0;
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 4) == 0) opc = 11'($urandom_range(4, 2047));
         else                           opc = 11'($urandom_range(0, 3));
         ab   = (opc < 11'd4 && $urandom_range(0, 4) == 0) ? $urandom_range(0, lat_ref(int'(opc))) : -1;
         dab  = ($urandom_range(0, 5) == 0);
         keep = !dab && ($urandom_range(0, 2) == 0);
         run_op(opc, $urandom, $urandom, ab, $urandom_range(0, 2), keep, dab);
         if (!keep || ab >= 0) begin
            copro_valid = 1'b0;
            for (int i = 0; i < $urandom_range(0, 2); i++) tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
